// File: rtl/apb_crc_engine.sv
// APB slave CRC accelerator: byte FIFO feeding a bit-serial, MSB-first CRC engine.
// Parameterised width, polynomial, init and output XOR; wait states on full FIFO or busy CRC read.
module apb_crc_engine #(
    parameter int unsigned CRC_W      = 8,
    parameter logic [31:0] POLY       = 32'h07,
    parameter logic [31:0] INIT       = 32'h0,
    parameter logic [31:0] XOR_OUT    = 32'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        p_clk_i,
    input  logic        p_rstn_i,
    input  logic        p_sel_i,
    input  logic        p_enable_i,
    input  logic        p_we_i,
    input  logic [31:0] p_adr_i,
    input  logic [31:0] p_dat_i,
    output logic [31:0] p_dat_o,
    output logic        p_ready,
    output logic        p_slverr
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W  = XOR_OUT[CRC_W-1:0];

    localparam logic [3:0] ADR_DATA = 4'h0;
    localparam logic [3:0] ADR_CRC  = 4'h4;
    localparam logic [3:0] ADR_STAT = 4'h8;
    localparam logic [3:0] ADR_CTRL = 4'hC;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [CRC_W-1:0]     crc_q, crc_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic [7:0]           mem_q [FIFO_DEPTH];

    logic                 access;
    logic                 push;
    logic                 pop;
    logic                 clear;
    logic                 busy;
    logic                 fifo_empty;
    logic                 fb;
    logic [CRC_W-1:0]     crc_out;
    logic [31:0]          status;
    logic                 unused_bits;

    assign unused_bits = ^{p_adr_i[31:4], p_dat_i[31:8]};

    assign access     = p_sel_i & p_enable_i;
    assign fifo_empty = (count_q == '0);
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign crc_out    = crc_q ^ XOR_W;
    assign status     = {16'h0, 8'(count_q), 5'h0, fifo_empty, full_q, busy};
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !clear;

    // APB decode: completion, error response, read mux and side-effect strobes
    always_comb begin
        p_ready  = 1'b0;
        p_slverr = 1'b0;
        p_dat_o  = '0;
        push     = 1'b0;
        clear    = 1'b0;
        if (access) begin
            p_ready = 1'b1;
            case (p_adr_i[3:0])
                ADR_DATA: begin
                    if (p_we_i) begin
                        p_ready = !full_q;
                        push    = !full_q;
                    end else begin
                        p_slverr = 1'b1;
                    end
                end
                ADR_CRC: begin
                    if (!p_we_i) begin
                        p_ready = !busy;
                        if (!busy) p_dat_o = 32'(crc_out);
                    end else begin
                        p_slverr = 1'b1;
                    end
                end
                ADR_STAT: begin
                    if (!p_we_i) p_dat_o = status;
                    else         p_slverr = 1'b1;
                end
                ADR_CTRL: begin
                    if (p_we_i) clear = p_dat_i[0];
                    else        p_slverr = 1'b1;
                end
                default: p_slverr = 1'b1;
            endcase
        end
    end

    // Engine state register and datapath flops
    always_ff @(posedge p_clk_i or negedge p_rstn_i) begin
        if (!p_rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            crc_q    <= INIT_W;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge p_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= p_dat_i[7:0];
    end

    // Engine next state: one load cycle, then eight shift cycles per byte
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_d = S_SHIFT;
                        cnt_d   = 3'd7;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == 3'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Engine outputs: CRC update, shift register and FIFO bookkeeping
    always_comb begin
        crc_d    = crc_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fb       = 1'b0;
        if (clear) begin
            crc_d    = INIT_W;
            shift_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (state_q == S_SHIFT) begin
                fb      = crc_q[CRC_W-1] ^ shift_q[7];
                crc_d   = (crc_q << 1) ^ (fb ? POLY_W : '0);
                shift_d = {shift_q[6:0], 1'b0};
            end
            if (pop) begin
                shift_d  = mem_q[rd_ptr_q];
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            case ({push, pop})
                2'b10:   count_d = CNT_W'(count_q + 1'b1);
                2'b01:   count_d = CNT_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CNT_W'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_apb_crc_engine.sv
// Directed bench for apb_crc_engine: a default CRC-8 instance and a CRC-16/CCITT instance
// share the clock, reset and APB wires; use16 steers select and read-back to one of them.
module tb_apb_crc_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel, enable, we, use16;
    logic [31:0] adr, wdat;
    logic        sel8, sel16;
    logic [31:0] dat8, dat16, rdat;
    logic        ready8, ready16, ready;
    logic        err8, err16, slverr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  str [9];

    always #5 clk = ~clk;

    assign sel8   = sel & !use16;
    assign sel16  = sel & use16;
    assign rdat   = use16 ? dat16 : dat8;
    assign ready  = use16 ? ready16 : ready8;
    assign slverr = use16 ? err16 : err8;

    apb_crc_engine u_dut8 (
        .p_clk_i    (clk),
        .p_rstn_i   (rst_n),
        .p_sel_i    (sel8),
        .p_enable_i (enable),
        .p_we_i     (we),
        .p_adr_i    (adr),
        .p_dat_i    (wdat),
        .p_dat_o    (dat8),
        .p_ready    (ready8),
        .p_slverr   (err8)
    );

    apb_crc_engine #(
        .CRC_W   (16),
        .POLY    (32'h1021),
        .INIT    (32'hFFFF),
        .XOR_OUT (32'h0)
    ) u_dut16 (
        .p_clk_i    (clk),
        .p_rstn_i   (rst_n),
        .p_sel_i    (sel16),
        .p_enable_i (enable),
        .p_we_i     (we),
        .p_adr_i    (adr),
        .p_dat_i    (wdat),
        .p_dat_o    (dat16),
        .p_ready    (ready16),
        .p_slverr   (err16)
    );

    // One APB transfer (setup + access); entered and left 1ns after a rising edge
    task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int waits);
        sel = 1'b1; enable = 1'b0; we = w; adr = a; wdat = d;
        rd = '0; er = 1'b0; waits = 0;
        @(posedge clk); #1 enable = 1'b1;
        forever begin
            @(negedge clk);
            if (ready) begin
                rd = rdat; er = slverr;
                break;
            end
            waits++;
            if (waits > 200) begin
                n_cmp++; n_err++;
                $display("FAIL apb_timeout adr=%h: ready still 0 after %0d cycles, need 1", a, waits);
                break;
            end
        end
        @(posedge clk); #1 sel = 1'b0; enable = 1'b0; we = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, a, d, rd, er, w);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int w;
        use16 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ready8, err8, dat8, ready16, err16, dat16} !== 68'h0) begin
            n_err++; $display("FAIL idle_outputs got %h need 0", {ready8, err8, dat8, ready16, err16, dat16});
        end
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL rst_status8 got %h need %h", rd, 32'h4); end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_crc8 got %h need %h", rd, 32'h0); end
        use16 = 1'b1;
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL rst_status16 got %h need %h", rd, 32'h4); end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'hFFFF) begin n_err++; $display("FAIL rst_crc16 got %h need %h", rd, 32'hFFFF); end
        use16 = 1'b0;
    endtask

    // Push 0x01 then hold access straight into a CRC read and count wait states
    task automatic test_single_byte();
        int waits;
        sel = 1'b1; enable = 1'b0; we = 1'b1; adr = 32'h0; wdat = 32'h1;
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_push_ready got %b need 1", ready); end
        @(posedge clk); #1 we = 1'b0; adr = 32'h4;
        waits = 0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 || waits > 100) break;
            waits++;
        end
        n_cmp++; if (waits != 9) begin n_err++; $display("FAIL single_waits got %0d need 9", waits); end
        n_cmp++; if (rdat !== 32'h7) begin n_err++; $display("FAIL single_crc got %h need %h", rdat, 32'h7); end
        n_cmp++; if (slverr !== 1'b0) begin n_err++; $display("FAIL single_slverr got %b need 0", slverr); end
        @(posedge clk); #1 sel = 1'b0; enable = 1'b0;
        apb_wr(32'hC, 32'h1);
    endtask

    task automatic test_check_string();
        logic [31:0] rd; logic er; int w;
        for (int i = 0; i < 9; i++) apb_wr(32'h0, 32'(str[i]));
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (w == 0) begin n_err++; $display("FAIL crc8_stall got %0d waits need >0", w); end
        n_cmp++; if (rd !== 32'hF4) begin n_err++; $display("FAIL crc8_check got %h need %h", rd, 32'hF4); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w;
        logic        ew [7];
        logic [31:0] ea [7];
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ea = '{32'h0, 32'h4, 32'h2, 32'h6, 32'hC, 32'h8, 32'h2};
        for (int i = 0; i < 7; i++) begin
            apb_xfer(ew[i], ea[i], 32'h1, rd, er, w);
            n_cmp++;
            if (w != 0 || er !== 1'b1 || rd !== 32'h0) begin
                n_err++;
                $display("FAIL err_resp we=%b adr=%h got waits=%0d slverr=%b dat=%h need 0/1/0", ew[i], ea[i], w, er, rd);
            end
        end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'hF4 || er !== 1'b0) begin n_err++; $display("FAIL err_crc_kept got %h/%b need %h/0", rd, er, 32'hF4); end
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL err_status_kept got %h need %h", rd, 32'h4); end
    endtask

    task automatic test_crc16();
        logic [31:0] rd; logic er; int w;
        use16 = 1'b1;
        for (int i = 0; i < 9; i++) apb_wr(32'h0, 32'(str[i]));
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h29B1) begin n_err++; $display("FAIL crc16_check got %h need %h", rd, 32'h29B1); end
        use16 = 1'b0;
    endtask

    // One byte in the engine, four fill the FIFO, the fifth waits for the next pop
    task automatic test_fifo_full();
        logic [31:0] rd; logic er; int w;
        apb_wr(32'hC, 32'h1);
        apb_wr(32'h0, 32'h11);
        for (int k = 1; k <= 4; k++) begin
            apb_xfer(1'b1, 32'h0, 32'(k), rd, er, w);
            n_cmp++; if (w != 0) begin n_err++; $display("FAIL fill_write%0d got %0d waits need 0", k, w); end
        end
        apb_xfer(1'b1, 32'h0, 32'h5, rd, er, w);
        n_cmp++; if (w != 1 || er !== 1'b0) begin n_err++; $display("FAIL full_write5 got waits=%0d err=%b need 1/0", w, er); end
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h0403) begin n_err++; $display("FAIL full_status got %h need %h", rd, 32'h0403); end
    endtask

    task automatic test_clear();
        logic [31:0] rd; logic er; int w;
        apb_wr(32'hC, 32'h1);
        for (int k = 0; k < 4; k++) apb_wr(32'h0, 32'hA5);
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h0301) begin n_err++; $display("FAIL pre_clear_status got %h need %h", rd, 32'h0301); end
        apb_xfer(1'b1, 32'hC, 32'h1, rd, er, w);
        n_cmp++; if (w != 0 || er !== 1'b0) begin n_err++; $display("FAIL clear_write got waits=%0d err=%b need 0/0", w, er); end
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL clear_status got %h need %h", rd, 32'h4); end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h0 || w != 0) begin n_err++; $display("FAIL clear_crc got %h waits=%0d need 0/0", rd, w); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w;
        use16 = 1'b1;
        for (int i = 0; i < 3; i++) apb_wr(32'h0, 32'(str[i]));
        use16 = 1'b0;
        apb_wr(32'h0, 32'hFF);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL rmid_status8 got %h need %h", rd, 32'h4); end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rmid_crc8 got %h need %h", rd, 32'h0); end
        use16 = 1'b1;
        apb_xfer(1'b0, 32'h8, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL rmid_status16 got %h need %h", rd, 32'h4); end
        apb_xfer(1'b0, 32'h4, 32'h0, rd, er, w);
        n_cmp++; if (rd !== 32'hFFFF) begin n_err++; $display("FAIL rmid_crc16 got %h need %h", rd, 32'hFFFF); end
        use16 = 1'b0;
    endtask

    initial begin
        str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst_n = 1'b0; sel = 1'b0; enable = 1'b0; we = 1'b0; use16 = 1'b0;
        adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_byte();
        test_check_string();
        test_errors();
        test_crc16();
        test_fifo_full();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
